dma_controller: RTL and testbench

- Cycle-stealing DMA engine between the external device and data memory.
- On a device interrupt it:
  - raises a begin-interrupt to the CPU and takes a destination address and block count from the CPU;
  - reads each 64-bit device block by offset and writes it to memory as BURST_LEN 16-bit words, one granted bus burst per block.
- Releases the bus between blocks and signals the CPU with an end-interrupt pulse.

---
 rtl/dma_controller.sv | 187 ++++++++++++++++++
 tb/tb_dma_controller.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_controller.sv
// dma_controller
//   Cycle-stealing DMA engine that moves fixed-size device blocks into data
//   memory. A rising edge on dev_interrupt starts a command handshake with the
//   CPU. Each block is fetched by offset, buffered and written as BURST_LEN
//   words inside one granted bus burst. The bus is released between blocks.
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-high reset
//   dev_interrupt     device interrupt level (edge detected internally)
//   dev_offset        block select to device (all ones when idle)
//   dev_data          selected device block, combinational from dev_offset
//   dma_begin_int     asks the CPU for a command (held until cmd_valid)
//   cmd_valid/addr/blocks  CPU command: destination base and block count
//   br / bg           bus request / bus grant
//   mem_write/addr/data/ack  memory write port
//   dma_end_int       one-cycle transfer-complete pulse
//   busy              high whenever the engine is not idle
module dma_controller #(
  parameter int WORD_SIZE      = 16,
  parameter int DEVICE_BIT_LEN = 2,
  parameter int NUM_BLOCKS     = 3,
  parameter int BURST_LEN      = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            dev_interrupt,
  output logic [DEVICE_BIT_LEN-1:0]       dev_offset,
  input  logic [BURST_LEN*WORD_SIZE-1:0]  dev_data,
  output logic                            dma_begin_int,
  input  logic                            cmd_valid,
  input  logic [WORD_SIZE-1:0]            cmd_addr,
  input  logic [DEVICE_BIT_LEN-1:0]       cmd_blocks,
  output logic                            br,
  input  logic                            bg,
  output logic                            mem_write,
  output logic [WORD_SIZE-1:0]            mem_addr,
  output logic [WORD_SIZE-1:0]            mem_data,
  input  logic                            mem_ack,
  output logic                            dma_end_int,
  output logic                            busy
);

  localparam int BLK_W = BURST_LEN * WORD_SIZE;
  localparam int K_W   = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INT_REQ,
    S_FETCH,
    S_LATCH,
    S_REQ,
    S_WRITE,
    S_RELEASE,
    S_DONE
  } state_t;

  state_t                    state_q, state_d;
  logic                      dev_int_q;
  logic                      pending_q, pending_d;
  logic [WORD_SIZE-1:0]      base_q, base_d;
  logic [DEVICE_BIT_LEN-1:0] nblk_q, nblk_d;
  logic [DEVICE_BIT_LEN-1:0] blk_q, blk_d;
  logic [K_W-1:0]            k_q, k_d;
  logic [BLK_W-1:0]          buf_q, buf_d;

  logic                      start_s;
  logic [DEVICE_BIT_LEN-1:0] cmd_nblk_s;

  assign start_s = dev_interrupt & ~dev_int_q;

  // Requested count clamped to the number of blocks the device holds.
  assign cmd_nblk_s = (cmd_blocks > DEVICE_BIT_LEN'(NUM_BLOCKS)) ?
                      DEVICE_BIT_LEN'(NUM_BLOCKS) : cmd_blocks;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      dev_int_q <= 1'b0;
      pending_q <= 1'b0;
      base_q    <= '0;
      nblk_q    <= '0;
      blk_q     <= '0;
      k_q       <= '0;
      buf_q     <= '0;
    end else begin
      state_q   <= state_d;
      dev_int_q <= dev_interrupt;
      pending_q <= pending_d;
      base_q    <= base_d;
      nblk_q    <= nblk_d;
      blk_q     <= blk_d;
      k_q       <= k_d;
      buf_q     <= buf_d;
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    nblk_d  = nblk_q;
    blk_d   = blk_q;
    k_d     = k_q;
    buf_d   = buf_q;
    // One-deep memory of an interrupt that arrives while busy; a second
    // edge while already pending simply re-sets the same flag.
    pending_d = pending_q | (start_s & (state_q != S_IDLE));

    case (state_q)
      S_IDLE: begin
        if (start_s || pending_q) begin
          pending_d = 1'b0;
          state_d   = S_INT_REQ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_INT_REQ: begin
        if (cmd_valid) begin
          base_d  = cmd_addr;
          nblk_d  = cmd_nblk_s;
          blk_d   = '0;
          state_d = (cmd_nblk_s == '0) ? S_DONE : S_FETCH;
        end else begin
          state_d = S_INT_REQ;
        end
      end
      S_FETCH: begin
        state_d = S_LATCH;
      end
      S_LATCH: begin
        buf_d   = dev_data;
        k_d     = '0;
        state_d = S_REQ;
      end
      S_REQ: begin
        state_d = bg ? S_WRITE : S_REQ;
      end
      S_WRITE: begin
        // An ack wins over a simultaneous loss of grant.
        if (mem_ack) begin
          if (k_q == K_W'(BURST_LEN - 1)) begin
            k_d     = '0;
            blk_d   = blk_q + DEVICE_BIT_LEN'(1);
            state_d = S_RELEASE;
          end else begin
            k_d = k_q + K_W'(1);
          end
        end else if (!bg) begin
          state_d = S_REQ;
        end else begin
          state_d = S_WRITE;
        end
      end
      S_RELEASE: begin
        if (!bg) begin
          state_d = (blk_q < nblk_q) ? S_FETCH : S_DONE;
        end else begin
          state_d = S_RELEASE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Moore-decoded control outputs; only mem_write is qualified by bg so a
  // withdrawn grant stops the strobe in the same cycle.
  assign br            = (state_q == S_REQ) || (state_q == S_WRITE);
  assign mem_write     = (state_q == S_WRITE) && bg;
  assign dma_begin_int = (state_q == S_INT_REQ);
  assign dma_end_int   = (state_q == S_DONE);
  assign busy          = (state_q != S_IDLE);
  assign dev_offset    = ((state_q == S_FETCH) || (state_q == S_LATCH) ||
                          (state_q == S_REQ)   || (state_q == S_WRITE) ||
                          (state_q == S_RELEASE)) ? blk_q : '1;

  // Address wraps naturally at the word width.
  assign mem_addr = base_q + WORD_SIZE'(blk_q) * WORD_SIZE'(BURST_LEN) + WORD_SIZE'(k_q);
  assign mem_data = buf_q[WORD_SIZE*k_q +: WORD_SIZE];

endmodule

// File: tb/tb_dma_controller.sv
module tb_dma_controller;

  logic        clk;
  logic        reset;
  logic        dev_interrupt;
  logic [1:0]  dev_offset;
  logic [63:0] dev_data;
  logic        dma_begin_int;
  logic        cmd_valid;
  logic [15:0] cmd_addr;
  logic [1:0]  cmd_blocks;
  logic        br;
  logic        bg;
  logic        mem_write;
  logic [15:0] mem_addr;
  logic [15:0] mem_data;
  logic        mem_ack;
  logic        dma_end_int;
  logic        busy;

  logic [63:0] blk0, blk1, blk2;

  int tests;
  int fails;

  // Auto bus responder / monitor state
  logic        auto_bus;
  logic        br_prev;
  logic        br_mon;
  logic [15:0] wq_addr[$];
  logic [15:0] wq_data[$];
  int          end_cnt;
  int          br_rise;
  int          wr_cycles;

  dma_controller #(
    .WORD_SIZE(16), .DEVICE_BIT_LEN(2), .NUM_BLOCKS(3), .BURST_LEN(4)
  ) dut (
    .clk(clk), .reset(reset), .dev_interrupt(dev_interrupt),
    .dev_offset(dev_offset), .dev_data(dev_data),
    .dma_begin_int(dma_begin_int), .cmd_valid(cmd_valid),
    .cmd_addr(cmd_addr), .cmd_blocks(cmd_blocks),
    .br(br), .bg(bg), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_ack(mem_ack), .dma_end_int(dma_end_int),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    case (dev_offset)
      2'd0:    dev_data = blk0;
      2'd1:    dev_data = blk1;
      2'd2:    dev_data = blk2;
      default: dev_data = 64'h0;
    endcase
  end

  // bg follows br one cycle later, immediate ack; records acked writes.
  always @(negedge clk) begin
    if (auto_bus) begin
      bg      = br_prev;
      br_prev = br;
      mem_ack = 1'b1;
      #1;
      if (mem_write && mem_ack) begin
        wq_addr.push_back(mem_addr);
        wq_data.push_back(mem_data);
      end
      if (mem_write) wr_cycles++;
      if (br && !br_mon) br_rise++;
      br_mon = br;
      if (dma_end_int) end_cnt++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_mon();
    wq_addr.delete();
    wq_data.delete();
    end_cnt   = 0;
    br_rise   = 0;
    wr_cycles = 0;
  endtask

  task automatic pulse_int(input int hold);
    @(negedge clk);
    dev_interrupt = 1'b1;
    repeat (hold) @(negedge clk);
    dev_interrupt = 1'b0;
  endtask

  task automatic wait_begin(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      #2;
      if (dma_begin_int) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_end(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      #2;
      if (dma_end_int) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic send_cmd(input logic [15:0] addr, input logic [1:0] nb);
    cmd_addr   = addr;
    cmd_blocks = nb;
    cmd_valid  = 1'b1;
    @(negedge clk);
    cmd_valid  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    tests++; if (dma_begin_int !== 1'b0) begin fails++; $display("FAIL reset_begin_int: got %b expected 0", dma_begin_int); end
    tests++; if (br !== 1'b0) begin fails++; $display("FAIL reset_br: got %b expected 0", br); end
    tests++; if (mem_write !== 1'b0) begin fails++; $display("FAIL reset_mem_write: got %b expected 0", mem_write); end
    tests++; if (dma_end_int !== 1'b0) begin fails++; $display("FAIL reset_end_int: got %b expected 0", dma_end_int); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
    tests++; if (dev_offset !== 2'b11) begin fails++; $display("FAIL reset_dev_offset: got %b expected 11", dev_offset); end
    tests++; if (mem_addr !== 16'h0000) begin fails++; $display("FAIL reset_mem_addr: got %h expected 0000", mem_addr); end
    tests++; if (mem_data !== 16'h0000) begin fails++; $display("FAIL reset_mem_data: got %h expected 0000", mem_data); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_full_transfer();
    logic [15:0] exp_data [12];
    bit ok;
    exp_data = '{16'h0004, 16'h0003, 16'h0002, 16'h0001,
                 16'h4444, 16'h3333, 16'h2222, 16'h1111,
                 16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA};
    clear_mon();
    pulse_int(3);
    wait_begin(20, ok);
    tests++; if (ok !== 1'b1) begin fails++; $display("FAIL full_begin_int: got %b expected 1", ok); end
    send_cmd(16'h0100, 2'd3);
    wait_end(300, ok);
    tests++; if (ok !== 1'b1) begin fails++; $display("FAIL full_end_int: got %b expected 1", ok); end
    repeat (4) @(negedge clk);
    #2;
    tests++; if (wq_addr.size() !== 12) begin fails++; $display("FAIL full_write_count: got %0d expected 12", wq_addr.size()); end
    for (int i = 0; i < 12; i++) begin
      tests++;
      if (i >= wq_addr.size()) begin
        fails++; $display("FAIL full_write_%0d: missing, expected %h=%h", i, 16'h0100 + 16'(i), exp_data[i]);
      end else if (wq_addr[i] !== 16'h0100 + 16'(i) || wq_data[i] !== exp_data[i]) begin
        fails++; $display("FAIL full_write_%0d: got %h=%h expected %h=%h", i, wq_addr[i], wq_data[i], 16'h0100 + 16'(i), exp_data[i]);
      end
    end
    tests++; if (br_rise !== 3) begin fails++; $display("FAIL full_br_bursts: got %0d expected 3", br_rise); end
    tests++; if (end_cnt !== 1) begin fails++; $display("FAIL full_end_pulses: got %0d expected 1", end_cnt); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL full_idle_after: got %b expected 0", busy); end
  endtask

  task automatic test_zero_blocks();
    bit ok;
    clear_mon();
    pulse_int(3);
    wait_begin(20, ok);
    tests++; if (ok !== 1'b1) begin fails++; $display("FAIL zero_begin_int: got %b expected 1", ok); end
    send_cmd(16'h0200, 2'd0);
    wait_end(2, ok);
    tests++; if (ok !== 1'b1) begin fails++; $display("FAIL zero_end_timing: got %b expected 1", ok); end
    repeat (4) @(negedge clk);
    #2;
    tests++; if (end_cnt !== 1) begin fails++; $display("FAIL zero_end_pulses: got %0d expected 1", end_cnt); end
    tests++; if (br_rise !== 0) begin fails++; $display("FAIL zero_no_br: got %0d expected 0", br_rise); end
    tests++; if (wr_cycles !== 0) begin fails++; $display("FAIL zero_no_write: got %0d expected 0", wr_cycles); end
  endtask

  task automatic test_grant_withdraw();
    logic [15:0] la[$];
    logic [15:0] ld[$];
    logic [15:0] exp_data [4];
    logic [15:0] held;
    int phase;
    bit done;
    bit ok;
    exp_data = '{16'h0004, 16'h0003, 16'h0002, 16'h0001};
    @(negedge clk);
    #3;
    auto_bus = 1'b0;
    bg       = 1'b0;
    mem_ack  = 1'b0;
    pulse_int(3);
    wait_begin(20, ok);
    tests++; if (ok !== 1'b1) begin fails++; $display("FAIL gw_begin_int: got %b expected 1", ok); end
    send_cmd(16'h0100, 2'd1);
    phase = 0;
    done  = 1'b0;
    held  = 16'h0;
    for (int c = 0; c < 80 && !done; c++) begin
      @(negedge clk);
      case (phase)
        1: begin
          bg = 1'b0; mem_ack = 1'b0;
          #1;
          tests++; if (mem_write !== 1'b0) begin fails++; $display("FAIL gw_write_drops: got %b expected 0", mem_write); end
          tests++; if (br !== 1'b1) begin fails++; $display("FAIL gw_br_held: got %b expected 1", br); end
          phase = 2;
        end
        2: begin
          bg = 1'b0; mem_ack = 1'b0;
          #1;
          tests++; if (br !== 1'b1) begin fails++; $display("FAIL gw_br_req: got %b expected 1", br); end
          phase = 3;
        end
        default: begin
          bg = br; mem_ack = 1'b0;
          #1;
          if (mem_write) begin
            if (mem_addr == 16'h0102 && phase == 0) begin
              held  = mem_data;
              phase = 1;
            end else begin
              mem_ack = 1'b1;
              la.push_back(mem_addr);
              ld.push_back(mem_data);
            end
          end
        end
      endcase
      if (dma_end_int) done = 1'b1;
    end
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL gw_end_int: got %b expected 1", done); end
    tests++; if (held !== 16'h0002) begin fails++; $display("FAIL gw_held_data: got %h expected 0002", held); end
    tests++; if (la.size() !== 4) begin fails++; $display("FAIL gw_write_count: got %0d expected 4", la.size()); end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (i >= la.size()) begin
        fails++; $display("FAIL gw_write_%0d: missing", i);
      end else if (la[i] !== 16'h0100 + 16'(i) || ld[i] !== exp_data[i]) begin
        fails++; $display("FAIL gw_write_%0d: got %h=%h expected %h=%h", i, la[i], ld[i], 16'h0100 + 16'(i), exp_data[i]);
      end
    end
    @(negedge clk);
    #3;
    bg       = 1'b0;
    mem_ack  = 1'b0;
    br_prev  = 1'b0;
    br_mon   = 1'b0;
    auto_bus = 1'b1;
  endtask

  task automatic test_addr_wrap();
    logic [15:0] exp_addr [4];
    logic [15:0] exp_data [4];
    bit ok;
    exp_addr = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    exp_data = '{16'h0004, 16'h0003, 16'h0002, 16'h0001};
    clear_mon();
    pulse_int(3);
    wait_begin(20, ok);
    send_cmd(16'hFFFE, 2'd1);
    wait_end(100, ok);
    tests++; if (ok !== 1'b1) begin fails++; $display("FAIL wrap_end_int: got %b expected 1", ok); end
    repeat (2) @(negedge clk);
    #2;
    tests++; if (wq_addr.size() !== 4) begin fails++; $display("FAIL wrap_write_count: got %0d expected 4", wq_addr.size()); end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (i >= wq_addr.size()) begin
        fails++; $display("FAIL wrap_write_%0d: missing", i);
      end else if (wq_addr[i] !== exp_addr[i] || wq_data[i] !== exp_data[i]) begin
        fails++; $display("FAIL wrap_write_%0d: got %h=%h expected %h=%h", i, wq_addr[i], wq_data[i], exp_addr[i], exp_data[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    bit extra;
    clear_mon();
    pulse_int(3);
    wait_begin(20, ok);
    send_cmd(16'h0300, 2'd1);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #2;
      if (br) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    tests++; if (ok !== 1'b1) begin fails++; $display("FAIL b2b_br_seen: got %b expected 1", ok); end
    pulse_int(1);
    pulse_int(1);
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL b2b_busy_window: got %b expected 1", busy); end
    wait_end(60, ok);
    tests++; if (ok !== 1'b1) begin fails++; $display("FAIL b2b_first_end: got %b expected 1", ok); end
    @(negedge clk);
    wait_begin(4, ok);
    tests++; if (ok !== 1'b1) begin fails++; $display("FAIL b2b_second_req: got %b expected 1", ok); end
    send_cmd(16'h0500, 2'd0);
    wait_end(3, ok);
    tests++; if (ok !== 1'b1) begin fails++; $display("FAIL b2b_second_end: got %b expected 1", ok); end
    extra = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      #2;
      if (dma_begin_int || busy) extra = 1'b1;
    end
    tests++; if (extra !== 1'b0) begin fails++; $display("FAIL b2b_no_third_req: got %b expected 0", extra); end
    tests++; if (wq_addr.size() !== 4) begin fails++; $display("FAIL b2b_write_count: got %0d expected 4", wq_addr.size()); end
  endtask

  task automatic test_reset_mid_write();
    bit ok;
    bit extra;
    int nw;
    clear_mon();
    pulse_int(3);
    wait_begin(20, ok);
    send_cmd(16'h0400, 2'd3);
    pulse_int(1);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      #2;
      if (mem_write) begin ok = 1'b1; break; end
    end
    tests++; if (ok !== 1'b1) begin fails++; $display("FAIL rst_write_seen: got %b expected 1", ok); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #2;
    nw = wq_addr.size();
    tests++; if (br !== 1'b0) begin fails++; $display("FAIL rst_br: got %b expected 0", br); end
    tests++; if (mem_write !== 1'b0) begin fails++; $display("FAIL rst_mem_write: got %b expected 0", mem_write); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b expected 0", busy); end
    tests++; if (dev_offset !== 2'b11) begin fails++; $display("FAIL rst_dev_offset: got %b expected 11", dev_offset); end
    extra = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      #2;
      if (dma_begin_int || busy) extra = 1'b1;
    end
    tests++; if (extra !== 1'b0) begin fails++; $display("FAIL rst_no_pending: got %b expected 0", extra); end
    tests++; if (wq_addr.size() !== nw) begin fails++; $display("FAIL rst_no_more_writes: got %0d expected %0d", wq_addr.size(), nw); end
  endtask

  initial begin
    tests         = 0;
    fails         = 0;
    reset         = 1'b1;
    dev_interrupt = 1'b0;
    cmd_valid     = 1'b0;
    cmd_addr      = 16'h0000;
    cmd_blocks    = 2'd0;
    bg            = 1'b0;
    mem_ack       = 1'b0;
    auto_bus      = 1'b1;
    br_prev       = 1'b0;
    br_mon        = 1'b0;
    end_cnt       = 0;
    br_rise       = 0;
    wr_cycles     = 0;
    blk0          = 64'h0001_0002_0003_0004;
    blk1          = 64'h1111_2222_3333_4444;
    blk2          = 64'hAAAA_BBBB_CCCC_DDDD;

    test_reset();
    test_full_transfer();
    test_zero_blocks();
    test_grant_withdraw();
    test_addr_wrap();
    test_back_to_back();
    test_reset_mid_write();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
